// File: rtl/map_hit_arbiter_pkg.sv
// Shared constants, state encoding and tile helper for map_hit_arbiter.
// Optional feature macro: MAPHIT_USER_PRIORITY_EN (requester 0 priority).
package map_hit_arbiter_pkg;

  localparam int TILE_SHIFT = 4;

  localparam logic [1:0] DIR_UP = 2'd3;
  localparam logic [1:0] DIR_DN = 2'd2;
  localparam logic [1:0] DIR_LT = 2'd1;
  localparam logic [1:0] DIR_RT = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_PROBE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [15:0] tile_of(
    input logic [15:0] px,
    input logic [15:0] off
  );
    logic [15:0] sum;
    sum = px + off;
    return sum >> TILE_SHIFT;
  endfunction

endpackage

// File: rtl/map_hit_arbiter_rr_arb.sv
// Round-robin requester select with optional fixed priority for requester 0.
// Used by map_hit_arbiter (MAPHIT_USER_PRIORITY_EN drives i_prio).
module maphit_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  input  logic               i_prio,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx
);

  logic [IW-1:0] w_j;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_j     = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_j = IW'((int'(i_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_j]) begin
        w_found   = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx     = w_j;
      end
    end
    if (i_prio && i_req[0]) begin
      o_gnt = NUM_REQ'(1);
      o_idx = '0;
    end
  end

endmodule

// File: rtl/map_hit_arbiter.sv
// Shared map-RAM collision prober: arbitrates requesters, probes 4 neighbours.
// Macro MAPHIT_USER_PRIORITY_EN gives requester 0 fixed priority.
module map_hit_arbiter
  import map_hit_arbiter_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] SOLID_MIN = 8'h80
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [NUM_REQ-1:0]    iReq,
  input  logic [10*NUM_REQ-1:0] iXS,
  input  logic [10*NUM_REQ-1:0] iYS,
  input  logic [10*NUM_REQ-1:0] iXE,
  input  logic [10*NUM_REQ-1:0] iYE,
  input  logic [15:0]           iFXS,
  input  logic [15:0]           iFYS,
  input  logic [15:0]           iMapWidth,
  output logic [15:0]           oMapAddr,
  output logic                  oMapRd,
  input  logic [7:0]            iMapData,
  output logic [NUM_REQ-1:0]    oAck,
  output logic [3:0]            oDirect,
  output logic                  oBusy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef MAPHIT_USER_PRIORITY_EN
  localparam logic PRIO = 1'b1;
`else
  localparam logic PRIO = 1'b0;
`endif

  state_t r_state, w_next;

  logic [IW-1:0]      r_ptr, r_win;
  logic [NUM_REQ-1:0] r_gnt;
  logic [9:0]         r_xs, r_ys, r_xe, r_ye;
  logic [15:0]        r_fxs, r_fys;
  logic [1:0]         r_cnt;
  logic               r_prb_vld, r_prb_blk;
  logic [1:0]         r_prb_dir;
  logic [3:0]         r_pass, r_direct;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gidx, w_ptr_nxt;
  logic [15:0]        w_px, w_py, w_tx, w_ty, w_addr;
  logic [1:0]         w_dir;
  logic               w_blk, w_smp;
  logic [3:0]         w_pass_now;

  maphit_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .i_req  (iReq),
    .i_ptr  (r_ptr),
    .i_prio (PRIO),
    .o_gnt  (w_gnt),
    .o_idx  (w_gidx)
  );

  assign w_ptr_nxt = (w_gidx == IW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

  // Probe order up, down, left, right maps counter 0..3 onto bits 3..0.
  assign w_dir = DIR_UP - r_cnt;

  always_comb begin
    w_px  = 16'(r_xs);
    w_py  = 16'(r_ys);
    w_blk = 1'b0;
    unique case (w_dir)
      DIR_UP: begin
        w_py  = 16'(r_ys) - 16'd1;
        w_blk = (r_ys == 10'd0);
      end
      DIR_DN: w_py = 16'(r_ye) + 16'd1;
      DIR_LT: begin
        w_px  = 16'(r_xs) - 16'd1;
        w_blk = (r_xs == 10'd0);
      end
      DIR_RT: w_px = 16'(r_xe) + 16'd1;
    endcase
    w_tx = tile_of(w_px, r_fxs);
    w_ty = tile_of(w_py, r_fys);
    if (w_dir == DIR_RT && w_tx >= iMapWidth) w_blk = 1'b1;
    w_addr = w_ty * iMapWidth + w_tx;
  end

  assign w_smp = !r_prb_blk && (iMapData < SOLID_MIN);

  always_comb begin
    w_pass_now = r_pass;
    w_pass_now[r_prb_dir] = w_smp;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (|iReq) w_next = ST_GRANT;
      ST_GRANT: w_next = ST_PROBE;
      ST_PROBE: if (r_cnt == 2'd3) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_gnt     <= '0;
      r_xs      <= '0;
      r_ys      <= '0;
      r_xe      <= '0;
      r_ye      <= '0;
      r_fxs     <= '0;
      r_fys     <= '0;
      r_cnt     <= '0;
      r_prb_vld <= 1'b0;
      r_prb_blk <= 1'b0;
      r_prb_dir <= '0;
      r_pass    <= '0;
      r_direct  <= '0;
    end else begin
      r_state   <= w_next;
      r_prb_vld <= (r_state == ST_PROBE);
      r_prb_dir <= w_dir;
      r_prb_blk <= w_blk;
      if (r_prb_vld) r_pass <= w_pass_now;
      unique case (r_state)
        ST_IDLE: if (|iReq) begin
          r_win <= w_gidx;
          r_gnt <= w_gnt;
          if (!(PRIO && iReq[0])) r_ptr <= w_ptr_nxt;
        end
        ST_GRANT: begin
          r_xs  <= iXS[int'(r_win)*10 +: 10];
          r_ys  <= iYS[int'(r_win)*10 +: 10];
          r_xe  <= iXE[int'(r_win)*10 +: 10];
          r_ye  <= iYE[int'(r_win)*10 +: 10];
          r_fxs <= iFXS;
          r_fys <= iFYS;
          r_cnt <= '0;
        end
        ST_PROBE: r_cnt <= r_cnt + 2'd1;
        // Right probe data lands this cycle; fold it in directly.
        ST_DRAIN: r_direct <= w_pass_now;
        default: ;
      endcase
    end
  end

  assign oMapRd   = (r_state == ST_PROBE);
  assign oMapAddr = (r_state == ST_PROBE) ? w_addr : 16'd0;
  assign oAck     = (r_state == ST_DONE) ? r_gnt : '0;
  assign oDirect  = r_direct;
  assign oBusy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_map_hit_arbiter.sv
// Self-checking bench for map_hit_arbiter against a behavioural model.
// Honours MAPHIT_USER_PRIORITY_EN when defined.
module tb_map_hit_arbiter;

  localparam int         N     = 4;
  localparam logic [7:0] SOLID = 8'h80;

`ifdef MAPHIT_USER_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            iCLK = 1'b0;
  logic            iRST;
  logic [N-1:0]    iReq;
  logic [10*N-1:0] iXS, iYS, iXE, iYE;
  logic [15:0]     iFXS, iFYS, iMapWidth;
  logic [15:0]     oMapAddr;
  logic            oMapRd;
  logic [7:0]      iMapData = 8'h00;
  logic [N-1:0]    oAck;
  logic [3:0]      oDirect;
  logic            oBusy;

  map_hit_arbiter #(.NUM_REQ(N), .SOLID_MIN(SOLID)) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iReq      (iReq),
    .iXS       (iXS),
    .iYS       (iYS),
    .iXE       (iXE),
    .iYE       (iYE),
    .iFXS      (iFXS),
    .iFYS      (iFYS),
    .iMapWidth (iMapWidth),
    .oMapAddr  (oMapAddr),
    .oMapRd    (oMapRd),
    .iMapData  (iMapData),
    .oAck      (oAck),
    .oDirect   (oDirect),
    .oBusy     (oBusy)
  );

  always #5 iCLK = ~iCLK;

  logic [7:0] mem [65536];
  always @(posedge iCLK) if (oMapRd) iMapData <= mem[oMapAddr];

  int npass = 0, nfail = 0, ntot = 0;
  int ptr = 0;
  logic [3:0] last_dir = 4'b0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void probe(input int d, input int xs, input int ys,
                                input int xe, input int ye, input int fx,
                                input int fy, input int wd,
                                output int addr, output bit blk);
    int px, py, tx, ty;
    px = xs; py = ys;
    case (d)
      0: py = ys - 1;
      1: py = ye + 1;
      2: px = xs - 1;
      default: px = xe + 1;
    endcase
    tx = ((px + fx) & 32'hFFFF) >> 4;
    ty = ((py + fy) & 32'hFFFF) >> 4;
    addr = (ty * wd + tx) & 32'hFFFF;
    blk = (d == 0 && ys == 0) || (d == 2 && xs == 0) || (d == 3 && tx >= wd);
  endfunction

  function automatic int pick(input logic [N-1:0] r);
    if (PRIO && r[0]) return 0;
    for (int i = 0; i < N; i++)
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic set_box(input int r, input int xs, input int ys, input int xe, input int ye);
    iXS[r*10 +: 10] = 10'(xs);
    iYS[r*10 +: 10] = 10'(ys);
    iXE[r*10 +: 10] = 10'(xe);
    iYE[r*10 +: 10] = 10'(ye);
  endtask

  task automatic rand_inputs();
    for (int r = 0; r < N; r++) begin
      int xs, ys;
      xs = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 1023));
      ys = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 1023));
      set_box(r, xs, ys, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    end
    iFXS = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
    iFYS = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
  endtask

  // Caller sets iReq one cycle before this is entered (cycle 0).
  task automatic query(input bit drop, input bit disturb);
    int w, xs, ys, xe, ye, fx, fy, wd;
    int addr [4];
    bit blk [4];
    logic [3:0] exp_dir;
    w = pick(iReq);
    if (w < 0) begin
      chk("winner_exists", 32'd0, 32'd1);
      return;
    end
    if (!(PRIO && iReq[0])) ptr = (w + 1) % N;
    xs = int'(iXS[w*10 +: 10]); ys = int'(iYS[w*10 +: 10]);
    xe = int'(iXE[w*10 +: 10]); ye = int'(iYE[w*10 +: 10]);
    fx = int'(iFXS); fy = int'(iFYS); wd = int'(iMapWidth);
    for (int d = 0; d < 4; d++) begin
      probe(d, xs, ys, xe, ye, fx, fy, wd, addr[d], blk[d]);
      exp_dir[3-d] = !blk[d] && (mem[addr[d]] < SOLID);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge iCLK);
      if (k >= 2 && k <= 5) begin
        chk("map_rd", 32'(oMapRd), 32'd1);
        chk("map_addr", 32'(oMapAddr), 32'(addr[k-2]));
      end else begin
        chk("map_rd_idle", 32'(oMapRd), 32'd0);
      end
      chk("busy", 32'(oBusy), (k <= 7) ? 32'd1 : 32'd0);
      if (k == 7) begin
        chk("ack", 32'(oAck), 32'(1 << w));
        chk("direct", 32'(oDirect), 32'(exp_dir));
        last_dir = exp_dir;
      end else begin
        chk("ack_quiet", 32'(oAck), 32'd0);
        chk("direct_hold", 32'(oDirect), 32'(last_dir));
      end
      if (k == 2 && disturb) rand_inputs();
      if (k == 3 && drop) iReq = '0;
    end
  endtask

  initial begin
    int a;
    bit b;
    iRST = 1'b1;
    iReq = '0;
    iXS = '0; iYS = '0; iXE = '0; iYE = '0;
    iFXS = 16'd0; iFYS = 16'd0; iMapWidth = 16'd20;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (2) @(negedge iCLK);
    chk("rst_ack", 32'(oAck), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_rd", 32'(oMapRd), 32'd0);
    chk("rst_addr", 32'(oMapAddr), 32'd0);
    chk("rst_dir", 32'(oDirect), 32'd0);
    iRST = 1'b0;
    @(negedge iCLK);

    // open field
    set_box(0, 32, 48, 47, 63);
    iReq = 4'b0001;
    query(0, 0);
    chk("open_dir", 32'(last_dir), 32'hF);

    // solid chip above
    probe(0, 32, 64, 47, 79, 0, 0, 20, a, b);
    mem[a] = 8'h90;
    set_box(0, 32, 64, 47, 79);
    query(0, 0);
    chk("solid_dir", 32'(last_dir), 32'h7);

    // map edges: up/left at 0, right tile equals width
    set_box(0, 0, 0, 319, 15);
    query(0, 0);
    chk("edge_dir", 32'(last_dir), 32'h4);
    iReq = '0;

    // fairness from a fresh pointer
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    ptr = 0;
    last_dir = 4'b0000;
    for (int r = 0; r < N; r++) set_box(r, 16 * r + 16, 100, 16 * r + 31, 115);
    iReq = 4'b1111;
    for (int q = 0; q < 5; q++) query(0, 0);
    iReq = '0;

    // winner drops mid-probe, inputs disturbed after latch
    set_box(1, 200, 200, 215, 215);
    iReq = 4'b0010;
    query(1, 1);
    iReq = '0;

    // reset during probe
    iReq = 4'b1000;
    repeat (3) @(negedge iCLK);
    chk("pre_rst_busy", 32'(oBusy), 32'd1);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("abort_ack", 32'(oAck), 32'd0);
    chk("abort_busy", 32'(oBusy), 32'd0);
    chk("abort_rd", 32'(oMapRd), 32'd0);
    chk("abort_addr", 32'(oMapAddr), 32'd0);
    chk("abort_dir", 32'(oDirect), 32'd0);
    iRST = 1'b0;
    iReq = '0;
    ptr = 0;
    last_dir = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge iCLK);
      chk("post_abort_ack", 32'(oAck), 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int q = 0; q < 25; q++) begin
      rand_inputs();
      iMapWidth = 16'($urandom_range(1, 64));
      iReq = 4'($urandom_range(1, 15));
      query(0, 0);
    end
    iReq = '0;
    @(negedge iCLK);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
